// File: rtl/serial_deserializer.sv
// Serial-to-parallel receiver: assembles SOF-framed single-bit words into WIDTH-bit
// words and presents them on a valid/ready register, flagging words lost to back-pressure.
module serial_deserializer #(
  parameter int    WIDTH     = 8,
  parameter string MSB_FIRST = "TRUE"
) (
  input  logic             CK,
  input  logic             RST,
  input  logic             D,
  input  logic             D_VALID,
  input  logic             SOF,
  output logic [WIDTH-1:0] Q,
  output logic             Q_VALID,
  input  logic             Q_READY,
  output logic             OVERFLOW,
  output logic             BUSY
);

  localparam int               CW   = $clog2(WIDTH + 1);
  localparam bit               MSBF = (MSB_FIRST == "TRUE");
  localparam logic [CW-1:0]    LAST = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic {HUNT, SHIFT} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic [WIDTH-1:0] sreg, sreg_nxt;
  logic             done;
  logic             slot_free;

  // Writes received bit number k into its lane of the word, honouring bit order.
  function automatic logic [WIDTH-1:0] place(input logic [WIDTH-1:0] w,
                                             input logic [CW-1:0]    k,
                                             input logic             b);
    logic [CW-1:0]    pos;
    logic [WIDTH-1:0] m;
    pos = MSBF ? (LAST - k) : k;
    m   = ONE << pos;
    return b ? (w | m) : (w & ~m);
  endfunction

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    sreg_nxt  = sreg;
    done      = 1'b0;
    if (D_VALID) begin
      if (SOF) begin
        // A new frame start always wins; any partial word is abandoned.
        sreg_nxt  = place('0, '0, D);
        cnt_nxt   = CW'(1);
        state_nxt = SHIFT;
      end else if (state == SHIFT) begin
        sreg_nxt = place(sreg, cnt, D);
        if (cnt == LAST) begin
          done      = 1'b1;
          cnt_nxt   = '0;
          state_nxt = HUNT;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
    end
  end

  assign slot_free = !Q_VALID || Q_READY;
  assign BUSY      = (state == SHIFT);

  always_ff @(posedge CK) begin
    if (RST) begin
      state    <= HUNT;
      cnt      <= '0;
      sreg     <= '0;
      Q        <= '0;
      Q_VALID  <= 1'b0;
      OVERFLOW <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      sreg     <= sreg_nxt;
      OVERFLOW <= 1'b0;
      if (done && slot_free) begin
        Q       <= sreg_nxt;
        Q_VALID <= 1'b1;
      end else begin
        if (done) OVERFLOW <= 1'b1;
        if (Q_VALID && Q_READY) Q_VALID <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_serial_deserializer.sv
// Directed bench for serial_deserializer: one MSB-first and one LSB-first instance
// share the same stimulus; each scenario task checks its own expected values.
module tb_serial_deserializer;

  logic       CK = 1'b0;
  logic       RST, D, D_VALID, SOF, Q_READY;
  logic [7:0] mq, lq;
  logic       mqv, lqv, movf, lovf, mbusy, lbusy;
  int         checks = 0;
  int         failures = 0;

  always #5 CK = ~CK;

  serial_deserializer #(.WIDTH(8), .MSB_FIRST("TRUE")) u_msb (
    .CK(CK), .RST(RST), .D(D), .D_VALID(D_VALID), .SOF(SOF),
    .Q(mq), .Q_VALID(mqv), .Q_READY(Q_READY), .OVERFLOW(movf), .BUSY(mbusy));

  serial_deserializer #(.WIDTH(8), .MSB_FIRST("FALSE")) u_lsb (
    .CK(CK), .RST(RST), .D(D), .D_VALID(D_VALID), .SOF(SOF),
    .Q(lq), .Q_VALID(lqv), .Q_READY(Q_READY), .OVERFLOW(lovf), .BUSY(lbusy));

  // Apply inputs, let one rising edge sample them, then settle 1 time unit past it.
  task automatic drive(input logic d, input logic sof, input logic v);
    D = d; SOF = sof; D_VALID = v;
    @(posedge CK);
    #1;
  endtask

  // Sends the first n bits of w in transmit order (w[7] first), SOF on bit 0.
  task automatic send_bits(input logic [7:0] w, input int n);
    logic [7:0] s;
    s = w;
    for (int k = 0; k < n; k++) begin
      drive(s[7], k == 0, 1'b1);
      s = s << 1;
    end
  endtask

  task automatic test_reset;
    RST = 1'b1;
    drive(1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    RST = 1'b0;
    checks++; if (mq !== 8'h00) begin failures++; $display("FAIL reset_q got=%h exp=00", mq); end
    checks++; if (mqv !== 1'b0) begin failures++; $display("FAIL reset_qvalid got=%b exp=0", mqv); end
    checks++; if (mbusy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", mbusy); end
    checks++; if (movf !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%b exp=0", movf); end
  endtask

  task automatic test_msb_word;
    Q_READY = 1'b0;
    send_bits(8'hA5, 1);
    checks++; if (mbusy !== 1'b1) begin failures++; $display("FAIL msb_busy_rise got=%b exp=1", mbusy); end
    drive(1'b0, 1'b0, 1'b1); drive(1'b1, 1'b0, 1'b1); drive(1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b1); drive(1'b1, 1'b0, 1'b1); drive(1'b0, 1'b0, 1'b1);
    checks++; if (mqv !== 1'b0) begin failures++; $display("FAIL msb_early_valid got=%b exp=0", mqv); end
    drive(1'b1, 1'b0, 1'b1);
    checks++; if (mq !== 8'hA5) begin failures++; $display("FAIL msb_q got=%h exp=a5", mq); end
    checks++; if (mqv !== 1'b1) begin failures++; $display("FAIL msb_qvalid got=%b exp=1", mqv); end
    checks++; if (mbusy !== 1'b0) begin failures++; $display("FAIL msb_busy_fall got=%b exp=0", mbusy); end
    checks++; if (lq !== 8'hA5) begin failures++; $display("FAIL lsb_pal_q got=%h exp=a5", lq); end
    drive(1'b0, 1'b0, 1'b0);
    checks++; if (mqv !== 1'b1 || mq !== 8'hA5) begin failures++; $display("FAIL msb_hold got=%b/%h exp=1/a5", mqv, mq); end
    Q_READY = 1'b1;
    drive(1'b0, 1'b0, 1'b0);
    checks++; if (mqv !== 1'b0) begin failures++; $display("FAIL msb_drain got=%b exp=0", mqv); end
    checks++; if (mq !== 8'hA5) begin failures++; $display("FAIL msb_q_after_drain got=%h exp=a5", mq); end
  endtask

  task automatic test_lsb_gaps;
    logic [7:0] s;
    s = 8'hA5;
    Q_READY = 1'b1;
    for (int k = 0; k < 8; k++) begin
      drive(s[7], k == 0, 1'b1);
      s = s << 1;
      if (k < 7) begin
        checks++; if (lqv !== 1'b0) begin failures++; $display("FAIL lsb_early_valid k=%0d got=%b exp=0", k, lqv); end
        // Gap cycle with a stray SOF: must not restart the word.
        drive(1'b1, 1'b1, 1'b0);
        checks++; if (lbusy !== 1'b1 || lqv !== 1'b0) begin failures++; $display("FAIL lsb_gap k=%0d got=%b/%b exp=1/0", k, lbusy, lqv); end
      end
    end
    checks++; if (lq !== 8'hA5) begin failures++; $display("FAIL lsb_q got=%h exp=a5", lq); end
    checks++; if (lqv !== 1'b1) begin failures++; $display("FAIL lsb_qvalid got=%b exp=1", lqv); end
    drive(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_resync;
    Q_READY = 1'b1;
    send_bits(8'hA0, 3);
    send_bits(8'hF0, 8);
    checks++; if (mq !== 8'hF0) begin failures++; $display("FAIL resync_q got=%h exp=f0", mq); end
    checks++; if (mqv !== 1'b1) begin failures++; $display("FAIL resync_qvalid got=%b exp=1", mqv); end
    checks++; if (movf !== 1'b0) begin failures++; $display("FAIL resync_ovf got=%b exp=0", movf); end
    drive(1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 8; k++) drive(1'b1, 1'b0, 1'b1);
    checks++; if (mqv !== 1'b0 || mbusy !== 1'b0) begin failures++; $display("FAIL hunt_nosof got=%b/%b exp=0/0", mqv, mbusy); end
    checks++; if (mq !== 8'hF0) begin failures++; $display("FAIL hunt_q got=%h exp=f0", mq); end
  endtask

  task automatic test_back_to_back;
    Q_READY = 1'b0;
    send_bits(8'h3C, 8);
    checks++; if (mq !== 8'h3C || mqv !== 1'b1) begin failures++; $display("FAIL bp_first got=%h/%b exp=3c/1", mq, mqv); end
    checks++; if (movf !== 1'b0) begin failures++; $display("FAIL bp_first_ovf got=%b exp=0", movf); end
    send_bits(8'hC3, 8);
    checks++; if (movf !== 1'b1) begin failures++; $display("FAIL bp_ovf_pulse got=%b exp=1", movf); end
    checks++; if (mq !== 8'h3C || mqv !== 1'b1) begin failures++; $display("FAIL bp_hold got=%h/%b exp=3c/1", mq, mqv); end
    drive(1'b0, 1'b0, 1'b0);
    checks++; if (movf !== 1'b0) begin failures++; $display("FAIL bp_ovf_width got=%b exp=0", movf); end
    Q_READY = 1'b1;
    drive(1'b0, 1'b0, 1'b0);
    checks++; if (mqv !== 1'b0 || mq !== 8'h3C) begin failures++; $display("FAIL bp_deliver got=%b/%h exp=0/3c", mqv, mq); end
    drive(1'b0, 1'b0, 1'b0);
    checks++; if (mqv !== 1'b0) begin failures++; $display("FAIL bp_once got=%b exp=0", mqv); end
  endtask

  task automatic test_drain_load;
    Q_READY = 1'b0;
    send_bits(8'h11, 8);
    checks++; if (mq !== 8'h11 || mqv !== 1'b1) begin failures++; $display("FAIL dl_first got=%h/%b exp=11/1", mq, mqv); end
    send_bits(8'h22, 7);
    Q_READY = 1'b1;
    drive(1'b0, 1'b0, 1'b1);
    checks++; if (mq !== 8'h22) begin failures++; $display("FAIL dl_q got=%h exp=22", mq); end
    checks++; if (mqv !== 1'b1) begin failures++; $display("FAIL dl_qvalid got=%b exp=1", mqv); end
    checks++; if (movf !== 1'b0) begin failures++; $display("FAIL dl_ovf got=%b exp=0", movf); end
    drive(1'b0, 1'b0, 1'b0);
    checks++; if (mqv !== 1'b0) begin failures++; $display("FAIL dl_drain got=%b exp=0", mqv); end
  endtask

  task automatic test_reset_mid;
    Q_READY = 1'b0;
    send_bits(8'h55, 8);
    send_bits(8'h9A, 5);
    RST = 1'b1;
    drive(1'b1, 1'b0, 1'b1);
    RST = 1'b0;
    checks++; if (mq !== 8'h00 || mqv !== 1'b0) begin failures++; $display("FAIL rstmid_q got=%h/%b exp=00/0", mq, mqv); end
    checks++; if (mbusy !== 1'b0 || movf !== 1'b0) begin failures++; $display("FAIL rstmid_ctl got=%b/%b exp=0/0", mbusy, movf); end
    Q_READY = 1'b1;
    send_bits(8'h81, 8);
    checks++; if (mq !== 8'h81 || mqv !== 1'b1) begin failures++; $display("FAIL rstmid_next got=%h/%b exp=81/1", mq, mqv); end
    checks++; if (lq !== 8'h81) begin failures++; $display("FAIL rstmid_lsb got=%h exp=81", lq); end
  endtask

  initial begin
    RST = 1'b1; D = 1'b0; D_VALID = 1'b0; SOF = 1'b0; Q_READY = 1'b0;
    #1;
    test_reset;
    test_msb_word;
    test_lsb_gaps;
    test_resync;
    test_back_to_back;
    test_drain_load;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
